vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scanout engine, the next generation of the fixed 640x480 driver. It generates VGA timing from parameters and reads colour indices from the framebuffer RAM. Indices are translated to RGB through a writable palette. Every sync and blank signal is delay-matched to the RAM and palette pipeline, and optional integer pixel replication scales low-resolution framebuffers. It sits between the framebuffer RAM read port and the VGA pins, in the pixel clock domain.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync lengths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync lengths in lines
- H_POL / V_POL, 0 / 0, sync active level (0 = active-low)
- COLOR_BITS, 5, bits per RGB channel
- INDEX_BITS, 4, framebuffer colour-index width
- ADDR_BITS, 19, framebuffer address width
- RAM_LATENCY, 1, cycles from `addr` change to valid `data` (1..4)
- SCALE_SHIFT, 0, pixel replication factor is 2^SCALE_SHIFT in both axes (0..2)

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- rst_pixel_n  in  1  reset; synchronous, active-low
- addr  out  ADDR_BITS  framebuffer read address
- data  in  INDEX_BITS  colour index returned by RAM
- pal_we  in  1  palette write strobe
- pal_waddr  in  INDEX_BITS  palette entry to write
- pal_wdata  in  3*COLOR_BITS  entry value, laid out {R,G,B}
- vga_hsync / vga_vsync  out  1  sync outputs, registered
- vga_red / vga_green / vga_blue  out  COLOR_BITS  colour outputs, registered
- vblank  out  1  high while the line on the pins is at or beyond V_ACTIVE
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the pins

## Operation
- Counters:
  - H_TOTAL = sum of the H terms; V_TOTAL = sum of the V terms.
  - sx counts 0..H_TOTAL-1 and wraps.
  - sy increments when sx wraps and itself wraps at V_TOTAL-1.
- Sync and enable decode:
  - hsync is active when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC.
  - vsync is decoded the same way from sy and the V terms.
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
- Address generation:
  - In active area: addr = (sy>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (sx>>SCALE_SHIFT), truncated to ADDR_BITS.
  - Outside active area: addr = 0.
  - No multiplier. Use a row-base accumulator:
    - Add H_ACTIVE>>SCALE_SHIFT at the end of each active line whose sy low SCALE_SHIFT bits are all ones.
    - Clear the accumulator at the sy wrap.
- Palette:
  - 2^INDEX_BITS entries of 3*COLOR_BITS, all cleared to 0 on reset.
  - Lookup is registered.
  - A write and a read of the same entry in the same cycle returns the old value; the new value is visible the next cycle.
  - Writes are accepted in any cycle, including active video.
- Output:
  - When aligned de = 1: colour outputs = palette[data] split R = [3C-1:2C], G = [2C-1:C], B = [C-1:0], where C = COLOR_BITS.
  - When aligned de = 0: all colour outputs = 0.
  - Sync outputs = decoded sync XOR inactive level. Active-low: pin is 0 during sync. Active-high: pin is 1 during sync.
- Alignment: hsync, vsync, de, vblank and the frame flag pass through a shift register of depth L-1 so they reach the pins in the same cycle as the pixel they belong to.

## Timing
- Pipeline latency L = RAM_LATENCY + 3, from counter state (sx, sy) to pins:
  - addr register (1)
  - RAM (RAM_LATENCY)
  - palette register (1)
  - output register (1)
- Reset (rst_pixel_n sampled 0), values forced on the next edge:
  - sx, sy, row base and addr = 0
  - colour outputs = 0
  - vga_hsync = ~H_POL, vga_vsync = ~V_POL
  - vblank = 0, frame_start = 0
  - all delay stages cleared to inactive
  - palette cleared
- After reset:
  - The first cycle with rst_pixel_n = 1 has (sx, sy) = (0,0).
  - frame_start pulses L cycles later, then every H_TOTAL*V_TOTAL cycles.
- Reset mid-frame aborts immediately. No partial line completes; the restart follows the post-reset behaviour above.
- Line wrap and frame wrap in the same cycle (sx = H_TOTAL-1, sy = V_TOTAL-1): both counters go to 0 and the row base clears on the same edge.
- addr changes at most once per 2^SCALE_SHIFT cycles within an active line.

## Test plan
- Reset values: hold rst_pixel_n = 0 for 5 cycles with defaults. All colour outputs are 0, both syncs are 1, addr = 0. After release, frame_start rises exactly 4 cycles later.
- Horizontal and vertical timing with defaults:
  - vga_hsync is low for 96 cycles, with the falling edge 656 cycles after the line's first pixel; the period is 800.
  - vga_vsync is low for 1600 cycles; the frame period is 420000 cycles.
  - vblank is high for lines 480..524.
- Latency, with RAM_LATENCY = 2 and a RAM model returning data = addr[3:0], palette entry i = {i,i,i}:
  - Pixel (0,0) reaches the pins 5 cycles after counter (0,0) with RGB = 0.
  - Pixel (5,0) has RGB = 5.
  - Colour is 0 in the cycle after pixel 639.
- Palette hazard: during active video, write entry 3 = 0x7FFF in the same cycle index 3 is looked up. The old value is output; the next index-3 pixel shows 0x7FFF.
- Scaling, SCALE_SHIFT = 1: the addr sequence on line 0 is 0,0,1,1,...,319,319. Line 1 repeats from 0. Line 2 starts at 320. At sy = 479, the last address is 76799.
- Mid-frame reset: assert reset at sy = 200. Outputs return to reset values, and the next frame_start pulse comes L cycles after release.

Source files
------------

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Parametrised VGA scanout engine. Free-running horizontal/vertical counters
// generate the raster, a row-base accumulator turns the raster position into
// a framebuffer read address (with optional 2^SCALE_SHIFT pixel replication),
// the returned colour index is translated through a writable palette, and the
// sync/blank/frame flags are delayed so they reach the pins together with the
// pixel they describe.
//
// Ports:
//   pixel_clk    pixel clock, the only clock
//   rst_pixel_n  synchronous active-low reset
//   addr         framebuffer read address (registered)
//   data         colour index returned by the framebuffer RAM
//   pal_we       palette write strobe
//   pal_waddr    palette entry to write
//   pal_wdata    palette entry value, {R,G,B}
//   vga_hsync    horizontal sync pin (registered)
//   vga_vsync    vertical sync pin (registered)
//   vga_red      red channel (registered)
//   vga_green    green channel (registered)
//   vga_blue     blue channel (registered)
//   vblank       high while the line on the pins is in vertical blanking
//   frame_start  one-cycle pulse coincident with pixel (0,0) on the pins
// ---------------------------------------------------------------------------
module vga_scanout #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit H_POL       = 1'b0,
   parameter bit V_POL       = 1'b0,
   parameter int COLOR_BITS  = 5,
   parameter int INDEX_BITS  = 4,
   parameter int ADDR_BITS   = 19,
   parameter int RAM_LATENCY = 1,
   parameter int SCALE_SHIFT = 0
) (
   input  logic                    pixel_clk,
   input  logic                    rst_pixel_n,
   output logic [ADDR_BITS-1:0]    addr,
   input  logic [INDEX_BITS-1:0]   data,
   input  logic                    pal_we,
   input  logic [INDEX_BITS-1:0]   pal_waddr,
   input  logic [3*COLOR_BITS-1:0] pal_wdata,
   output logic                    vga_hsync,
   output logic                    vga_vsync,
   output logic [COLOR_BITS-1:0]   vga_red,
   output logic [COLOR_BITS-1:0]   vga_green,
   output logic [COLOR_BITS-1:0]   vga_blue,
   output logic                    vblank,
   output logic                    frame_start
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW        = $clog2(H_TOTAL);
   localparam int VW        = $clog2(V_TOTAL);
   localparam int LAT       = RAM_LATENCY + 3;
   localparam int DLY       = LAT - 1;
   localparam int PAL_DEPTH = 1 << INDEX_BITS;
   localparam int RGB_BITS  = 3 * COLOR_BITS;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [VW-1:0]        SY_MASK  = VW'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(H_ACTIVE >> SCALE_SHIFT);

   localparam bit H_IDLE = !H_POL;
   localparam bit V_IDLE = !V_POL;

   // Timing flags carried down the alignment delay line, all active-high.
   typedef struct packed {
      logic frame;
      logic vblank;
      logic vsync;
      logic hsync;
      logic de;
   } ctl_t;

   logic [HW-1:0]        r_sx;
   logic [VW-1:0]        r_sy;
   logic [ADDR_BITS-1:0] r_rowBase;
   logic [RGB_BITS-1:0]  r_palette [PAL_DEPTH];
   logic [RGB_BITS-1:0]  r_palOut;
   ctl_t                 r_dly [DLY];
   ctl_t                 w_ctl;
   ctl_t                 w_aligned;

   // Decode the current raster position into the flags for this pixel.
   always_comb begin
      w_ctl        = '0;
      w_ctl.de     = (r_sx < H_ACT) && (r_sy < V_ACT);
      w_ctl.hsync  = (r_sx >= HS_START) && (r_sx < HS_END);
      w_ctl.vsync  = (r_sy >= VS_START) && (r_sy < VS_END);
      w_ctl.vblank = (r_sy >= V_ACT);
      w_ctl.frame  = (r_sx == '0) && (r_sy == '0);
      w_aligned    = r_dly[DLY-1];
   end

   // Raster counters and row-base accumulator. The row base steps by one
   // scaled line width only after the last replicated copy of a source line,
   // so every replicated line re-reads the same framebuffer row. A frame wrap
   // takes priority and clears the row base on the same edge.
   always_ff @(posedge pixel_clk) begin
      if (!rst_pixel_n) begin
         r_sx      <= '0;
         r_sy      <= '0;
         r_rowBase <= '0;
      end else if (r_sx == H_LAST) begin
         r_sx <= '0;
         if (r_sy == V_LAST) begin
            r_sy      <= '0;
            r_rowBase <= '0;
         end else begin
            r_sy <= r_sy + VW'(1);
            if ((r_sy < V_ACT) && ((r_sy & SY_MASK) == SY_MASK)) begin
               r_rowBase <= r_rowBase + ROW_STEP;
            end
         end
      end else begin
         r_sx <= r_sx + HW'(1);
      end
   end

   // Framebuffer address: row base plus the scaled column, parked at zero
   // outside the visible area.
   always_ff @(posedge pixel_clk) begin
      if (!rst_pixel_n) begin
         addr <= '0;
      end else if (w_ctl.de) begin
         addr <= r_rowBase + ADDR_BITS'(r_sx >> SCALE_SHIFT);
      end else begin
         addr <= '0;
      end
   end

   // Palette storage. Writes land on the clock edge, so a lookup of the same
   // entry in the write cycle still sees the previous contents.
   always_ff @(posedge pixel_clk) begin
      if (!rst_pixel_n) begin
         for (int i = 0; i < PAL_DEPTH; i++) begin
            r_palette[i] <= '0;
         end
      end else if (pal_we) begin
         r_palette[pal_waddr] <= pal_wdata;
      end
   end

   // Registered palette lookup of the index coming back from the RAM.
   always_ff @(posedge pixel_clk) begin
      if (!rst_pixel_n) begin
         r_palOut <= '0;
      end else begin
         r_palOut <= r_palette[data];
      end
   end

   // Delay line that walks the timing flags alongside the address, RAM and
   // palette stages; its last stage lines up with r_palOut.
   always_ff @(posedge pixel_clk) begin
      if (!rst_pixel_n) begin
         for (int i = 0; i < DLY; i++) begin
            r_dly[i] <= '0;
         end
      end else begin
         r_dly[0] <= w_ctl;
         for (int i = 1; i < DLY; i++) begin
            r_dly[i] <= r_dly[i-1];
         end
      end
   end

   // Output register: colour is blanked outside the active area and the sync
   // flags are converted to the requested pin polarity.
   always_ff @(posedge pixel_clk) begin
      if (!rst_pixel_n) begin
         vga_hsync   <= H_IDLE;
         vga_vsync   <= V_IDLE;
         vga_red     <= '0;
         vga_green   <= '0;
         vga_blue    <= '0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_hsync   <= w_aligned.hsync ^ H_IDLE;
         vga_vsync   <= w_aligned.vsync ^ V_IDLE;
         vblank      <= w_aligned.vblank;
         frame_start <= w_aligned.frame;
         if (w_aligned.de) begin
            vga_red   <= r_palOut[3*COLOR_BITS-1:2*COLOR_BITS];
            vga_green <= r_palOut[2*COLOR_BITS-1:COLOR_BITS];
            vga_blue  <= r_palOut[COLOR_BITS-1:0];
         end else begin
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Self-checking bench for vga_scanout on a shrunken raster (24x12 total,
// 16x8 visible), RAM latency 2, 2x replication and an active-high vsync.
// A cycle-indexed reference model feeds a scoreboard of expected pin and
// address values; a table of pixel vectors and a few hand sequences cover
// the palette hazard, scaling boundaries and reset behaviour.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

   localparam int HA  = 16;
   localparam int HFP = 2;
   localparam int HS  = 3;
   localparam int HBP = 3;
   localparam int VA  = 8;
   localparam int VFP = 1;
   localparam int VS  = 2;
   localparam int VBP = 1;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b1;
   localparam int CB  = 5;
   localparam int IB  = 4;
   localparam int AB  = 19;
   localparam int RL  = 2;
   localparam int SS  = 1;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FR  = HT * VT;
   localparam int L   = RL + 3;

   logic          pixel_clk   = 1'b0;
   logic          rst_pixel_n = 1'b0;
   logic [AB-1:0] addr;
   logic [IB-1:0] data        = '0;
   logic [IB-1:0] ramD1       = '0;
   logic          pal_we      = 1'b0;
   logic [IB-1:0] pal_waddr   = '0;
   logic [3*CB-1:0] pal_wdata = '0;
   logic          vga_hsync;
   logic          vga_vsync;
   logic [CB-1:0] vga_red;
   logic [CB-1:0] vga_green;
   logic [CB-1:0] vga_blue;
   logic          vblank;
   logic          frame_start;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        vb;
      logic        fs;
      logic [14:0] rgb;
   } pins_t;

   typedef struct {
      int          px;
      int          py;
      logic [14:0] rgb;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   int          n        = 0;
   bit          rstEdge  = 1'b0;
   logic [14:0] tbPal [16];
   pins_t       expQ[$];
   logic [AB-1:0] addrQ[$];

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .H_POL(HPOL), .V_POL(VPOL),
      .COLOR_BITS(CB), .INDEX_BITS(IB), .ADDR_BITS(AB),
      .RAM_LATENCY(RL), .SCALE_SHIFT(SS)
   ) dut (
      .pixel_clk(pixel_clk),
      .rst_pixel_n(rst_pixel_n),
      .addr(addr),
      .data(data),
      .pal_we(pal_we),
      .pal_waddr(pal_waddr),
      .pal_wdata(pal_wdata),
      .vga_hsync(vga_hsync),
      .vga_vsync(vga_vsync),
      .vga_red(vga_red),
      .vga_green(vga_green),
      .vga_blue(vga_blue),
      .vblank(vblank),
      .frame_start(frame_start)
   );

   // Pixel clock.
   always #5 pixel_clk = ~pixel_clk;

   // Framebuffer RAM model: two-cycle read returning the low address bits.
   always @(posedge pixel_clk) begin
      ramD1 <= addr[3:0];
      data  <= ramD1;
   end

   // Cycle index since reset release; equals the raster state index.
   always @(posedge pixel_clk) begin
      rstEdge <= !rst_pixel_n;
      if (!rst_pixel_n) n <= 0;
      else              n <= n + 1;
   end

   function automatic logic [14:0] palVal(input int i);
      logic [4:0] r, g, b;
      r = 5'(i);
      g = 5'(2 * i);
      b = 5'(31 - i);
      return {r, g, b};
   endfunction

   function automatic logic [AB-1:0] modelAddr(input int k);
      int sx, sy;
      sx = k % HT;
      sy = (k / HT) % VT;
      if (sx < HA && sy < VA) return AB'((sy >> SS) * (HA >> SS) + (sx >> SS));
      return '0;
   endfunction

   function automatic pins_t inactivePins();
      pins_t p;
      p.hs  = !HPOL;
      p.vs  = !VPOL;
      p.vb  = 1'b0;
      p.fs  = 1'b0;
      p.rgb = '0;
      return p;
   endfunction

   function automatic pins_t modelPins(input int k);
      int sx, sy;
      logic [AB-1:0] a;
      logic [3:0] idx;
      pins_t p;
      sx  = k % HT;
      sy  = (k / HT) % VT;
      a   = modelAddr(k);
      idx = a[3:0];
      p.hs  = ((sx >= HA + HFP) && (sx < HA + HFP + HS)) ? HPOL : !HPOL;
      p.vs  = ((sy >= VA + VFP) && (sy < VA + VFP + VS)) ? VPOL : !VPOL;
      p.vb  = (sy >= VA);
      p.fs  = (sx == 0) && (sy == 0);
      p.rgb = (sx < HA && sy < VA) ? tbPal[idx] : 15'h0000;
      return p;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at n=%0d: got %h, expected %h", name, n, act, exp);
      end
   endtask

   // Advance to the sample point of raster cycle 'target', bounded.
   task automatic waitState(input int target);
      int guard;
      guard = 0;
      do begin
         @(posedge pixel_clk);
         #1;
         guard++;
      end while (n != target && guard < 3000);
      if (n != target) begin
         checks++;
         failures++;
         $display("[TB] FAIL timeout waiting for n=%0d: got n=%0d", target, n);
      end
   endtask

   // Palette write issued so it is sampled at the end of raster cycle atN.
   task automatic applyStimulus(input int idx, input logic [14:0] val, input int atN);
      waitState(atN);
      @(negedge pixel_clk);
      pal_we    = 1'b1;
      pal_waddr = 4'(idx);
      pal_wdata = val;
      tbPal[idx] = val;
      @(posedge pixel_clk);
      #1;
      @(negedge pixel_clk);
      pal_we = 1'b0;
   endtask

   // Scoreboard: push the model's view of each raster cycle, compare pins L
   // cycles later and the address one cycle later. Reset cycles reload the
   // queues with the inactive values the pipeline shows while it refills.
   initial begin
      pins_t e;
      pins_t act;
      logic [AB-1:0] ea;
      forever begin
         @(posedge pixel_clk);
         #1;
         if (rstEdge) begin
            expQ.delete();
            addrQ.delete();
            for (int i = 0; i < L; i++) expQ.push_back(inactivePins());
            addrQ.push_back('0);
         end
         expQ.push_back(modelPins(n));
         addrQ.push_back(modelAddr(n));
         if (expQ.size() > L) begin
            e   = expQ.pop_front();
            act = {vga_hsync, vga_vsync, vblank, frame_start, vga_red, vga_green, vga_blue};
            checkOutput("pins", 32'(act), 32'(e));
         end
         if (addrQ.size() > 1) begin
            ea = addrQ.pop_front();
            checkOutput("addr", 32'(addr), 32'(ea));
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      vec_t vecs [11];
      vecs[0]  = '{0,  0, 15'h001F};
      vecs[1]  = '{5,  0, 15'h089D};
      vecs[2]  = '{15, 0, 15'h1DD8};
      vecs[3]  = '{16, 0, 15'h0000};
      vecs[4]  = '{3,  1, 15'h045E};
      vecs[5]  = '{0,  2, 15'h2217};
      vecs[6]  = '{14, 3, 15'h3FD0};
      vecs[7]  = '{2,  4, 15'h045E};
      vecs[8]  = '{23, 5, 15'h0000};
      vecs[9]  = '{10, 7, 15'h3752};
      vecs[10] = '{0,  8, 15'h0000};

      for (int i = 0; i < 16; i++) tbPal[i] = '0;

      repeat (5) @(negedge pixel_clk);
      checkOutput("reset addr", 32'(addr), 32'd0);
      checkOutput("reset rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
      checkOutput("reset hsync", 32'(vga_hsync), 32'd1);
      checkOutput("reset vsync", 32'(vga_vsync), 32'd0);
      rst_pixel_n = 1'b1;

      waitState(L - 1);
      checkOutput("frame_start early", 32'(frame_start), 32'd0);
      waitState(L);
      checkOutput("frame_start first", 32'(frame_start), 32'd1);

      for (int i = 0; i < 16; i++) applyStimulus(i, palVal(i), 200 + 2 * i);

      for (int v = 0; v < 11; v++) begin
         waitState(FR + vecs[v].py * HT + vecs[v].px + L);
         checkOutput($sformatf("pixel(%0d,%0d)", vecs[v].px, vecs[v].py),
                     32'({vga_red, vga_green, vga_blue}), 32'(vecs[v].rgb));
      end

      waitState(2 * FR + L);
      checkOutput("frame_start period", 32'(frame_start), 32'd1);
      applyStimulus(3, 15'h7FFF, 2 * FR + 7 + 3);
      waitState(2 * FR + 7 + L);
      checkOutput("hazard old", 32'({vga_red, vga_green, vga_blue}), 32'h0CDC);
      waitState(2 * FR + HT + 6 + L);
      checkOutput("hazard new", 32'({vga_red, vga_green, vga_blue}), 32'h7FFF);
      waitState(2 * FR + 2 * HT + 1);
      checkOutput("scale line2 base", 32'(addr), 32'd8);
      waitState(2 * FR + 7 * HT + 15 + 1);
      checkOutput("scale last addr", 32'(addr), 32'd31);
      waitState(2 * FR + 7 * HT + 16 + 1);
      checkOutput("addr blank", 32'(addr), 32'd0);

      waitState(3 * FR + 9 * HT + 22);
      checkOutput("vsync active", 32'(vga_vsync), 32'd1);
      @(negedge pixel_clk);
      rst_pixel_n = 1'b0;
      for (int i = 0; i < 16; i++) tbPal[i] = '0;
      @(posedge pixel_clk);
      #1;
      checkOutput("midreset addr", 32'(addr), 32'd0);
      checkOutput("midreset rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
      checkOutput("midreset hsync", 32'(vga_hsync), 32'd1);
      checkOutput("midreset vsync", 32'(vga_vsync), 32'd0);
      checkOutput("midreset vblank", 32'(vblank), 32'd0);
      checkOutput("midreset frame_start", 32'(frame_start), 32'd0);
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      rst_pixel_n = 1'b1;

      waitState(L - 1);
      checkOutput("restart frame_start early", 32'(frame_start), 32'd0);
      waitState(L);
      checkOutput("restart frame_start", 32'(frame_start), 32'd1);
      waitState(FR + L);
      checkOutput("restart period", 32'(frame_start), 32'd1);
      waitState(FR + L + 1);
      checkOutput("frame_start one cycle", 32'(frame_start), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
